// File: rtl/box_wrap_pipeline.sv
// rtl/box_wrap_pipeline.sv - elastic 4-stage wrapping paper / ribbon calculator with batch total
//
// Purpose: per l x w x h box, compute wrapping paper (mode 0) or ribbon
// length (mode 1), stream the result out on a valid/ready interface and
// accumulate a per-batch total that is published when the box tagged last
// leaves the block.
//
// Ports:
//   clk, reset                         rising-edge clock, asynchronous active-high reset
//   in_valid, in_ready                 box input handshake
//   in_mode, in_last                   0 = paper / 1 = ribbon, final box of the batch
//   in_length, in_width, in_height     box dimensions (unsigned)
//   res_valid, res_ready               per-box result handshake
//   res_last, res_value                last-box tag and result (modulo 2^RESULT_WIDTH)
//   total_valid                        one-cycle pulse: total_value/total_ovf just updated
//   total_value, total_ovf             batch total and batch carry-out flag

module box_wrap_pipeline #(
  parameter int SIZE_WIDTH   = 8,
  parameter int RESULT_WIDTH = 24,
  parameter int TOTAL_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic                    in_last,
  input  logic [SIZE_WIDTH-1:0]   in_length,
  input  logic [SIZE_WIDTH-1:0]   in_width,
  input  logic [SIZE_WIDTH-1:0]   in_height,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic                    res_last,
  output logic [RESULT_WIDTH-1:0] res_value,
  output logic                    total_valid,
  output logic [TOTAL_WIDTH-1:0]  total_value,
  output logic                    total_ovf
);

  // Internal widths sized so nothing is lost before the final truncation.
  localparam int AREA_W  = 2 * SIZE_WIDTH;       // one face area
  localparam int VOL_W   = 3 * SIZE_WIDTH;       // l*w*h
  localparam int ASUM_W  = AREA_W + 2;           // sum of three areas
  localparam int DSUM_W  = SIZE_WIDTH + 2;       // sum of three dims
  localparam int CALC_W0 = VOL_W + 4;            // covers both formulas
  localparam int CALC_W  = (CALC_W0 > RESULT_WIDTH) ? CALC_W0 : RESULT_WIDTH;

  // ---------------------------------------------------------------------
  // Elastic handshake: a stage can take new data when it is empty or its
  // current contents move on this cycle. The chain is purely combinational
  // from the output ready back to in_ready, so a full pipe with res_ready
  // high still accepts one box per cycle.
  // ---------------------------------------------------------------------
  logic s1_valid, s2_valid, s3_valid;
  logic s1_ready, s2_ready, s3_ready, s4_ready;

  assign s4_ready = !res_valid || res_ready;
  assign s3_ready = !s3_valid  || s4_ready;
  assign s2_ready = !s2_valid  || s3_ready;
  assign s1_ready = !s1_valid  || s2_ready;
  assign in_ready = s1_ready;

  // ---------------------------------------------------------------------
  // S1: register dimensions; face areas computed from the registers.
  // ---------------------------------------------------------------------
  logic [SIZE_WIDTH-1:0] s1_l, s1_w, s1_h;
  logic                  s1_mode, s1_last;
  logic [AREA_W-1:0]     s1_lw, s1_wh, s1_hl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_l     <= '0;
      s1_w     <= '0;
      s1_h     <= '0;
      s1_mode  <= 1'b0;
      s1_last  <= 1'b0;
    end else if (s1_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_l    <= in_length;
        s1_w    <= in_width;
        s1_h    <= in_height;
        s1_mode <= in_mode;
        s1_last <= in_last;
      end
    end
  end

  assign s1_lw = AREA_W'(s1_l) * AREA_W'(s1_w);
  assign s1_wh = AREA_W'(s1_w) * AREA_W'(s1_h);
  assign s1_hl = AREA_W'(s1_h) * AREA_W'(s1_l);

  // ---------------------------------------------------------------------
  // S2: register areas and dims; derive min area, sum of the two smallest
  // dims (total minus the largest, so ties need no special handling),
  // volume and the area sum.
  // ---------------------------------------------------------------------
  logic [SIZE_WIDTH-1:0] s2_l, s2_w, s2_h;
  logic [AREA_W-1:0]     s2_lw, s2_wh, s2_hl;
  logic                  s2_mode, s2_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_l     <= '0;
      s2_w     <= '0;
      s2_h     <= '0;
      s2_lw    <= '0;
      s2_wh    <= '0;
      s2_hl    <= '0;
      s2_mode  <= 1'b0;
      s2_last  <= 1'b0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_l    <= s1_l;
        s2_w    <= s1_w;
        s2_h    <= s1_h;
        s2_lw   <= s1_lw;
        s2_wh   <= s1_wh;
        s2_hl   <= s1_hl;
        s2_mode <= s1_mode;
        s2_last <= s1_last;
      end
    end
  end

  logic [AREA_W-1:0]     s2_min_lw_wh, s2_min_area;
  logic [SIZE_WIDTH-1:0] s2_max_lw, s2_max_dim;
  logic [DSUM_W-1:0]     s2_small_sum;
  logic [VOL_W-1:0]      s2_lwh;
  logic [ASUM_W-1:0]     s2_area_sum;

  assign s2_min_lw_wh = (s2_lw < s2_wh) ? s2_lw : s2_wh;
  assign s2_min_area  = (s2_min_lw_wh < s2_hl) ? s2_min_lw_wh : s2_hl;
  assign s2_max_lw    = (s2_l > s2_w) ? s2_l : s2_w;
  assign s2_max_dim   = (s2_max_lw > s2_h) ? s2_max_lw : s2_h;
  assign s2_small_sum = DSUM_W'(s2_l) + DSUM_W'(s2_w) + DSUM_W'(s2_h)
                      - DSUM_W'(s2_max_dim);
  assign s2_lwh       = VOL_W'(s2_lw) * VOL_W'(s2_h);
  assign s2_area_sum  = ASUM_W'(s2_lw) + ASUM_W'(s2_wh) + ASUM_W'(s2_hl);

  // ---------------------------------------------------------------------
  // S3: register the partial terms; select the formula for this box.
  // ---------------------------------------------------------------------
  logic [ASUM_W-1:0] s3_area_sum;
  logic [AREA_W-1:0] s3_min_area;
  logic [DSUM_W-1:0] s3_small_sum;
  logic [VOL_W-1:0]  s3_lwh;
  logic              s3_mode, s3_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s3_valid     <= 1'b0;
      s3_area_sum  <= '0;
      s3_min_area  <= '0;
      s3_small_sum <= '0;
      s3_lwh       <= '0;
      s3_mode      <= 1'b0;
      s3_last      <= 1'b0;
    end else if (s3_ready) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_area_sum  <= s2_area_sum;
        s3_min_area  <= s2_min_area;
        s3_small_sum <= s2_small_sum;
        s3_lwh       <= s2_lwh;
        s3_mode      <= s2_mode;
        s3_last      <= s2_last;
      end
    end
  end

  logic [CALC_W-1:0]       s3_paper, s3_ribbon;
  logic [RESULT_WIDTH-1:0] s3_result;

  assign s3_paper  = (CALC_W'(s3_area_sum) << 1) + CALC_W'(s3_min_area);
  assign s3_ribbon = (CALC_W'(s3_small_sum) << 1) + CALC_W'(s3_lwh);
  // Truncation gives the modulo-2^RESULT_WIDTH result.
  assign s3_result = RESULT_WIDTH'(s3_mode ? s3_ribbon : s3_paper);

  // ---------------------------------------------------------------------
  // S4: output register. Holds while res_valid && !res_ready.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_last  <= 1'b0;
      res_value <= '0;
    end else if (s4_ready) begin
      res_valid <= s3_valid;
      res_last  <= s3_valid && s3_last;
      if (s3_valid) begin
        res_value <= s3_result;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Batch accumulator. The last box's own result is folded into the
  // published total on the same edge that clears the running sum, so the
  // next batch starts from zero with no idle cycle.
  // ---------------------------------------------------------------------
  logic                   res_hs;
  logic [TOTAL_WIDTH-1:0] acc;
  logic                   acc_ovf;
  logic [TOTAL_WIDTH:0]   acc_sum;

  assign res_hs  = res_valid && res_ready;
  assign acc_sum = (TOTAL_WIDTH + 1)'(acc) + (TOTAL_WIDTH + 1)'(res_value);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc         <= '0;
      acc_ovf     <= 1'b0;
      total_valid <= 1'b0;
      total_value <= '0;
      total_ovf   <= 1'b0;
    end else begin
      total_valid <= 1'b0;
      if (res_hs) begin
        if (res_last) begin
          total_value <= acc_sum[TOTAL_WIDTH-1:0];
          total_ovf   <= acc_ovf || acc_sum[TOTAL_WIDTH];
          total_valid <= 1'b1;
          acc         <= '0;
          acc_ovf     <= 1'b0;
        end else begin
          acc     <= acc_sum[TOTAL_WIDTH-1:0];
          acc_ovf <= acc_ovf || acc_sum[TOTAL_WIDTH];
        end
      end
    end
  end

endmodule
